accel_averager: RTL and testbench

Upstream conditioning stage of the Kalman-filter preprocessor. Accepts raw signed 16-bit x/y accelerometer samples with a per-sample valid strobe and accumulates blocks of 2^LOG2_N samples per axis. Each completed block is divided by N and presented as registered, held outputs `x_avg`/`y_avg`. These drive the combinational arctan stage's `x_in`/`y_in` directly. A one-cycle strobe marks each new average so the Kalman update can sample the angle.

---
 rtl/preproc_pkg.sv | 15 +
 rtl/accel_averager_if.sv | 28 ++
 rtl/avg_channel.sv | 55 +++++
 rtl/accel_averager.sv | 87 ++++++++
 tb/tb_accel_averager.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/preproc_pkg.sv
// Shared definitions for the Kalman preprocessor: sample width, averager FSM
// states and the signed sample type used by both the averager and arctan stages.
package preproc_pkg;

  localparam int DATA_W         = 16;
  localparam int LOG2_N_DEFAULT = 3;

  typedef enum logic {
    EMPTY,
    ACCUM
  } avg_state_e;

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/accel_averager_if.sv
// Sample/average bus between the accelerometer front end and the averager.
// The master drives raw samples and clear; the slave returns the held averages.
interface accel_averager_if #(
  parameter int DATA_W = preproc_pkg::DATA_W,
  parameter int LOG2_N = preproc_pkg::LOG2_N_DEFAULT
);

  logic                     clear;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] x_raw;
  logic signed [DATA_W-1:0] y_raw;
  logic signed [DATA_W-1:0] x_avg;
  logic signed [DATA_W-1:0] y_avg;
  logic                     avg_strobe;
  logic                     have_avg;
  logic [LOG2_N-1:0]        count;

  modport master (
    output clear, sample_valid, x_raw, y_raw,
    input  x_avg, y_avg, avg_strobe, have_avg, count
  );

  modport slave (
    input  clear, sample_valid, x_raw, y_raw,
    output x_avg, y_avg, avg_strobe, have_avg, count
  );

endinterface

// File: rtl/avg_channel.sv
// Single-axis block accumulator with divide-by-2^LOG2_N on the last sample.
// Define AVG_ROUND_EN for round-to-nearest (ties to +inf); otherwise floor.
module avg_channel #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear_i,
  input  logic                     accept_i,
  input  logic                     last_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] avg_o
);

  // One guard bit above the worst-case block sum absorbs the rounding addend.
  localparam int AW = DATA_W + LOG2_N + 1;

  logic signed [AW-1:0]     acc_q;
  logic signed [AW-1:0]     sample_ext;
  logic signed [AW-1:0]     total;
  logic signed [AW-1:0]     total_r;
  logic signed [DATA_W-1:0] avg_d;
  logic signed [DATA_W-1:0] avg_q;

  assign sample_ext = {{(AW-DATA_W){sample_i[DATA_W-1]}}, sample_i};
  assign total      = acc_q + sample_ext;

`ifdef AVG_ROUND_EN
  localparam int ROUND_ADD = 1 << (LOG2_N - 1);
  assign total_r = total + AW'(ROUND_ADD);
`else
  assign total_r = total;
`endif

  assign avg_d = DATA_W'(total_r >>> LOG2_N);
  assign avg_o = avg_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
      avg_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (accept_i) begin
      if (last_i) begin
        acc_q <= '0;
        avg_q <= avg_d;
      end else begin
        acc_q <= total;
      end
    end
  end

endmodule

// File: rtl/accel_averager.sv
// Block averager for x/y accelerometer samples feeding the arctan stage.
// Rounding mode is selected in avg_channel by the AVG_ROUND_EN macro.
module accel_averager #(
  parameter int DATA_W = preproc_pkg::DATA_W,
  parameter int LOG2_N = preproc_pkg::LOG2_N_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  accel_averager_if.slave  bus
);

  import preproc_pkg::*;

  localparam logic [LOG2_N-1:0] LAST_COUNT = '1;

  avg_state_e        state_q;
  logic [LOG2_N-1:0] count_q;
  logic              strobe_q;
  logic              have_q;
  logic              accept;
  logic              last_sample;

  // clear has priority, so a sample arriving with clear is dropped.
  assign accept      = bus.sample_valid & ~bus.clear;
  assign last_sample = accept && (state_q == ACCUM) && (count_q == LAST_COUNT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      strobe_q <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (bus.clear) begin
        state_q <= EMPTY;
        count_q <= '0;
      end else if (accept) begin
        case (state_q)
          EMPTY: begin
            state_q <= ACCUM;
            count_q <= LOG2_N'(1);
          end
          ACCUM: begin
            if (last_sample) begin
              state_q  <= EMPTY;
              count_q  <= '0;
              strobe_q <= 1'b1;
              have_q   <= 1'b1;
            end else begin
              count_q <= count_q + LOG2_N'(1);
            end
          end
          default: begin
            state_q <= EMPTY;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_x (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (bus.clear),
    .accept_i (accept),
    .last_i   (last_sample),
    .sample_i (bus.x_raw),
    .avg_o    (bus.x_avg)
  );

  avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_y (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (bus.clear),
    .accept_i (accept),
    .last_i   (last_sample),
    .sample_i (bus.y_raw),
    .avg_o    (bus.y_avg)
  );

  assign bus.avg_strobe = strobe_q;
  assign bus.have_avg   = have_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_accel_averager.sv
// Directed bench for accel_averager with N=8; expectations follow AVG_ROUND_EN.
module tb_accel_averager;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 3;

`ifdef AVG_ROUND_EN
  localparam int EXP_POS4   = 1;
  localparam int EXP_NEG4   = 0;
  localparam int EXP_BLK0_X = 4;
  localparam int EXP_BLK0_Y = -3;
  localparam int EXP_BLK2_X = 20;
  localparam int EXP_BLK2_Y = -19;
`else
  localparam int EXP_POS4   = 0;
  localparam int EXP_NEG4   = -1;
  localparam int EXP_BLK0_X = 3;
  localparam int EXP_BLK0_Y = -4;
  localparam int EXP_BLK2_X = 19;
  localparam int EXP_BLK2_Y = -20;
`endif

  logic clk;
  logic n_rst;
  int   testsRun;
  int   failCount;
  int   strobeCount;

  accel_averager_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) bus ();

  accel_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at a falling edge and return at the next one.
  task automatic applyStimulus(input logic valid, input logic clr,
                               input int x, input int y);
    bus.sample_valid = valid;
    bus.clear        = clr;
    bus.x_raw        = DATA_W'(x);
    bus.y_raw        = DATA_W'(y);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag,
             $signed(observed), $signed(expected));
    end
  endtask

  initial begin
    testsRun     = 0;
    failCount    = 0;
    strobeCount  = 0;
    n_rst        = 1'b0;
    bus.sample_valid = 1'b1;
    bus.clear    = 1'b0;
    bus.x_raw    = 16'sd77;
    bus.y_raw    = 16'sd77;

    // Reset held with samples offered: nothing may be accepted.
    repeat (3) @(negedge clk);
    checkOutput("rst_x_avg", bus.x_avg, 0);
    checkOutput("rst_y_avg", bus.y_avg, 0);
    checkOutput("rst_strobe", bus.avg_strobe, 0);
    checkOutput("rst_have", bus.have_avg, 0);
    checkOutput("rst_count", bus.count, 0);
    bus.sample_valid = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);

    // First block: 8 x 100 / -100.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 100, -100);
    checkOutput("blk1_count4", bus.count, 4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 100, -100);
    checkOutput("blk1_strobe_early", bus.avg_strobe, 0);
    checkOutput("blk1_have_early", bus.have_avg, 0);
    applyStimulus(1'b1, 1'b0, 100, -100);
    checkOutput("blk1_x_avg", bus.x_avg, 100);
    checkOutput("blk1_y_avg", bus.y_avg, -100);
    checkOutput("blk1_strobe", bus.avg_strobe, 1);
    checkOutput("blk1_have", bus.have_avg, 1);
    checkOutput("blk1_count_wrap", bus.count, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("blk1_strobe_drop", bus.avg_strobe, 0);
    checkOutput("blk1_x_hold", bus.x_avg, 100);

    // Rounding on a positive residue.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 4, 0);
    checkOutput("round_pos4", bus.x_avg, EXP_POS4);
    checkOutput("round_pos4_y", bus.y_avg, 0);

    // Rounding on a negative residue.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, -4, 0);
    checkOutput("round_neg4", bus.x_avg, EXP_NEG4);

    // Full-scale inputs must not wrap.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32767, -32768);
    checkOutput("ext_x_max", bus.x_avg, 32767);
    checkOutput("ext_y_min", bus.y_avg, -32768);

    // Clear mid-block, with a sample on the same cycle that must be dropped.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 50, 50);
    checkOutput("clr_count5", bus.count, 5);
    applyStimulus(1'b1, 1'b1, 999, 999);
    checkOutput("clr_count0", bus.count, 0);
    checkOutput("clr_x_hold", bus.x_avg, 32767);
    checkOutput("clr_have_kept", bus.have_avg, 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 10, -10);
    checkOutput("clr_no_early_strobe", bus.avg_strobe, 0);
    checkOutput("clr_x_hold2", bus.x_avg, 32767);
    applyStimulus(1'b1, 1'b0, 10, -10);
    checkOutput("clr_strobe", bus.avg_strobe, 1);
    checkOutput("clr_x_avg", bus.x_avg, 10);
    checkOutput("clr_y_avg", bus.y_avg, -10);

    // Continuous stream: a strobe every 8th cycle, count cycling 0..7.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, i, -i);
      if (bus.avg_strobe) strobeCount++;
      checkOutput($sformatf("stream_strobe_%0d", i), bus.avg_strobe,
                  ((i % 8) == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("stream_count_%0d", i), bus.count, (i + 1) % 8);
      if (i == 7) begin
        checkOutput("stream_blk0_x", bus.x_avg, EXP_BLK0_X);
        checkOutput("stream_blk0_y", bus.y_avg, EXP_BLK0_Y);
      end
    end
    checkOutput("stream_strobe_total", strobeCount, 3);
    checkOutput("stream_blk2_x", bus.x_avg, EXP_BLK2_X);
    checkOutput("stream_blk2_y", bus.y_avg, EXP_BLK2_Y);

    // Asynchronous reset pulse partway through a block.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 300, 300);
    checkOutput("mid_count4", bus.count, 4);
    bus.sample_valid = 1'b0;
    #1 n_rst = 1'b0;
    #2;
    checkOutput("mid_rst_count", bus.count, 0);
    checkOutput("mid_rst_x_avg", bus.x_avg, 0);
    checkOutput("mid_rst_y_avg", bus.y_avg, 0);
    checkOutput("mid_rst_have", bus.have_avg, 0);
    #1 n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 200, 8);
    checkOutput("post_rst_no_strobe", bus.avg_strobe, 0);
    checkOutput("post_rst_have_low", bus.have_avg, 0);
    applyStimulus(1'b1, 1'b0, 200, 8);
    checkOutput("post_rst_strobe", bus.avg_strobe, 1);
    checkOutput("post_rst_x_avg", bus.x_avg, 200);
    checkOutput("post_rst_y_avg", bus.y_avg, 8);
    applyStimulus(1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
